// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - shared types and constants for the NES pad reader
package nes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_READ_LO,
        ST_READ_HI,
        ST_DONE
    } pad_state_t;

    // Button positions within game_input[7:0] (and within the new-press byte)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int DEFAULT_DIV         = 300;
    localparam int DEFAULT_POLL_CYCLES = 833333;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous input, resets high
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - polls an NES serial pad and presents held/new-press button state
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int DIV         = DEFAULT_DIV,
    parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [15:0] game_input,
    output logic        sample_valid
);

    localparam int TW = $clog2(POLL_CYCLES);
    localparam int CW = $clog2(2 * DIV);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYCLES - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(BTN_RIGHT);

    // A full poll must fit inside one poll period or a trigger could land outside IDLE
    if (POLL_CYCLES <= 17 * DIV + 4) begin : g_bad_poll_cycles
        $error("nes_pad_reader: POLL_CYCLES must exceed 17*DIV+4");
    end

    pad_state_t    state;
    logic [TW-1:0] poll_timer;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    prev_btn;
    logic [7:0]    cur_btn;
    logic          pad_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pad_data),
        .q     (pad_sync)
    );

    assign cur_btn = ~shift_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_timer <= '0;
        end else if (poll_timer == POLL_LAST) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + TW'(1);
        end
    end

    // pad_latch/pad_clk are set on the transition so they track the state register exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            bit_idx      <= '0;
            shift_reg    <= 8'hFF;
            prev_btn     <= 8'h00;
            game_input   <= 16'h0000;
            sample_valid <= 1'b0;
            pad_latch    <= 1'b0;
            pad_clk      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (poll_timer == POLL_LAST) begin
                        state     <= ST_LATCH;
                        pad_latch <= 1'b1;
                        div_cnt   <= '0;
                        shift_reg <= 8'hFF;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt == LATCH_LAST) begin
                        state     <= ST_READ_LO;
                        pad_latch <= 1'b0;
                        div_cnt   <= '0;
                        bit_idx   <= '0;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                ST_READ_LO: begin
                    if (div_cnt == HALF_LAST) begin
                        shift_reg[bit_idx] <= pad_sync;
                        div_cnt            <= '0;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_READ_HI;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                ST_READ_HI: begin
                    if (div_cnt == HALF_LAST) begin
                        state   <= ST_READ_LO;
                        pad_clk <= 1'b0;
                        div_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    game_input   <= {cur_btn & ~prev_btn, cur_btn};
                    prev_btn     <= cur_btn;
                    sample_valid <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

endmodule
